g3_resp_checker: RTL and testbench

Clocked response checker for the 6-input/2-output g3 logic block: the consuming end of the stimulus path. A driver presents each applied vector {a,b,c,d,e,f} with the observed g3 outputs {z1,z2} and the expected outputs. The checker accepts them over a valid/ready handshake, compares under a per-output mask, counts mismatches, and latches the first failure. It reports pass/fail once NVEC vectors are consumed, so the same vectors can be checked on the board without a simulator.

---
 rtl/g3_resp_checker.sv | 119 +++++++++++
 tb/tb_g3_resp_checker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/g3_resp_checker.sv
// g3_resp_checker: consumes applied-vector / observed / expected triples from a
// driver, compares observed against expected under a per-bit mask, counts
// mismatching vectors, captures the first failure and reports pass/fail after
// NVEC accepted vectors.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start, not accepting vectors
// S_RUN  | accepting vectors until NVEC have been transferred
// S_DONE | run finished, results held until the next start
module g3_resp_checker #(
    parameter int NVEC  = 3,
    parameter int IDX_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [5:0]       vec_in,
    input  logic [1:0]       z_obs,
    input  logic [1:0]       z_exp,
    input  logic [1:0]       z_mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [5:0]       first_err_vec,
    output logic [1:0]       first_err_obs
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t state;
    logic   xfer;
    logic   mismatch;

    // A masked bit never contributes, so z_mask=2'b11 always reads as a match.
    assign xfer     = vec_valid & vec_ready;
    assign mismatch = |((z_obs ^ z_exp) & ~z_mask);

    // Run sequencing plus all registered outputs; results are cleared on entry to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            vec_ready       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            vec_cnt         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_vec   <= '0;
            first_err_obs   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state           <= S_RUN;
                        vec_ready       <= 1'b1;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        vec_cnt         <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        first_err_vec   <= '0;
                        first_err_obs   <= '0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        vec_cnt <= vec_cnt + 1'b1;
                        if (mismatch) begin
                            if (err_cnt != CNT_MAX) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_idx   <= vec_cnt;
                                first_err_vec   <= vec_in;
                                first_err_obs   <= z_obs;
                            end
                        end
                        // The last vector's own result is folded in directly,
                        // since first_err_valid only updates on this same edge.
                        if (vec_cnt == LAST_IDX) begin
                            state     <= S_DONE;
                            vec_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= ~(first_err_valid | mismatch);
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    vec_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_g3_resp_checker.sv
// Directed testbench for g3_resp_checker: a default instance (NVEC=3, CNT_W=8)
// and a small instance (NVEC=6, CNT_W=2) for the error-counter saturation case.
module tb_g3_resp_checker;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic       vec_valid;
    logic       vec_ready;
    logic [5:0] vec_in;
    logic [1:0] z_obs, z_exp, z_mask;
    logic       busy, done, pass;
    logic [7:0] vec_cnt, err_cnt;
    logic       first_err_valid;
    logic [7:0] first_err_idx;
    logic [5:0] first_err_vec;
    logic [1:0] first_err_obs;

    logic       s_start;
    logic       s_valid;
    logic       s_ready;
    logic [5:0] s_vec_in;
    logic [1:0] s_obs, s_exp, s_mask;
    logic       s_busy, s_done, s_pass;
    logic [7:0] s_vec_cnt;
    logic [1:0] s_err_cnt;
    logic       s_fev;
    logic [7:0] s_fei;
    logic [5:0] s_fevec;
    logic [1:0] s_feobs;

    int tests = 0;
    int fails = 0;

    g3_resp_checker #(.NVEC(3), .IDX_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_in(vec_in),
        .z_obs(z_obs), .z_exp(z_exp), .z_mask(z_mask),
        .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
        .first_err_vec(first_err_vec), .first_err_obs(first_err_obs)
    );

    g3_resp_checker #(.NVEC(6), .IDX_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .vec_valid(s_valid), .vec_ready(s_ready), .vec_in(s_vec_in),
        .z_obs(s_obs), .z_exp(s_exp), .z_mask(s_mask),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt),
        .first_err_valid(s_fev), .first_err_idx(s_fei),
        .first_err_vec(s_fevec), .first_err_obs(s_feobs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one vector and holds valid until it is accepted (bounded wait).
    // vec_valid is left high so consecutive calls are back-to-back.
    task automatic send(input logic [5:0] v, input logic [1:0] e,
                        input logic [1:0] o, input logic [1:0] m);
        logic rdy;
        rdy = 1'b0;
        vec_in = v; z_exp = e; z_obs = o; z_mask = m;
        vec_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdy = vec_ready;
            tick();
            if (rdy) break;
        end
        if (!rdy) begin
            tests++; fails++;
            $display("FAIL send_timeout: vec_ready never high for vec %b", v);
        end
    endtask

    task automatic run_three(input logic [1:0] o1, input logic [1:0] o2);
        pulse_start();
        send(6'b011100, 2'b01, 2'b01, 2'b00);
        send(6'b010101, 2'b10, o1,    2'b00);
        send(6'b101010, 2'b11, o2,    2'b00);
        vec_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({vec_ready, busy, done, pass, vec_cnt, err_cnt, first_err_valid,
             first_err_idx, first_err_vec, first_err_obs} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b pass=%b vc=%0d ec=%0d fev=%b, want all 0",
                     vec_ready, busy, done, pass, vec_cnt, err_cnt, first_err_valid);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (vec_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_ready: got rdy=%b busy=%b, want 0 0", vec_ready, busy);
        end
    endtask

    task automatic test_all_pass();
        pulse_start();
        tests++;
        if (busy !== 1'b1 || vec_ready !== 1'b1) begin
            fails++;
            $display("FAIL run_entry: got busy=%b rdy=%b, want 1 1", busy, vec_ready);
        end
        send(6'b011100, 2'b01, 2'b01, 2'b00);
        send(6'b010101, 2'b10, 2'b10, 2'b00);
        tests++;
        if (vec_cnt !== 8'd2 || done !== 1'b0) begin
            fails++;
            $display("FAIL pass_mid: got vc=%0d done=%b, want 2 0", vec_cnt, done);
        end
        send(6'b101010, 2'b11, 2'b11, 2'b00);
        vec_valid = 1'b0;
        tests++;
        if ({done, busy, vec_ready, pass, vec_cnt, err_cnt, first_err_valid} !==
            {1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL pass_end: got done=%b busy=%b rdy=%b pass=%b vc=%0d ec=%0d fev=%b, want 1 0 0 1 3 0 0",
                     done, busy, vec_ready, pass, vec_cnt, err_cnt, first_err_valid);
        end
    endtask

    task automatic test_first_err();
        run_three(2'b11, 2'b11);
        tests++;
        if ({done, pass, err_cnt, first_err_valid, first_err_idx, first_err_vec, first_err_obs} !==
            {1'b1, 1'b0, 8'd1, 1'b1, 8'd1, 6'b010101, 2'b11}) begin
            fails++;
            $display("FAIL first_err_one: got done=%b pass=%b ec=%0d fev=%b idx=%0d vec=%b obs=%b, want 1 0 1 1 1 010101 11",
                     done, pass, err_cnt, first_err_valid, first_err_idx, first_err_vec, first_err_obs);
        end
        run_three(2'b11, 2'b10);
        tests++;
        if ({done, pass, err_cnt, first_err_valid, first_err_idx, first_err_vec, first_err_obs} !==
            {1'b1, 1'b0, 8'd2, 1'b1, 8'd1, 6'b010101, 2'b11}) begin
            fails++;
            $display("FAIL first_err_two: got done=%b pass=%b ec=%0d fev=%b idx=%0d vec=%b obs=%b, want 1 0 2 1 1 010101 11",
                     done, pass, err_cnt, first_err_valid, first_err_idx, first_err_vec, first_err_obs);
        end
    endtask

    task automatic test_stall();
        logic [5:0] pat;
        pat = 6'b100101;  // cycle k uses pat[5-k]: 1,0,0,1,0,1
        pulse_start();
        vec_in = 6'b000111; z_exp = 2'b01; z_obs = 2'b01; z_mask = 2'b00;
        for (int k = 0; k < 6; k++) begin
            vec_valid = pat[5-k];
            start = (k == 2);  // start inside RUN must not restart the run
            tick();
            if (k == 4) begin
                tests++;
                if (vec_cnt !== 8'd2 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_mid: got vc=%0d done=%b, want 2 0", vec_cnt, done);
                end
            end
        end
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || vec_cnt !== 8'd3 || pass !== 1'b1) begin
            fails++;
            $display("FAIL stall_end: got done=%b vc=%0d pass=%b, want 1 3 1", done, vec_cnt, pass);
        end
        vec_valid = 1'b1;
        repeat (3) tick();
        vec_valid = 1'b0;
        tests++;
        if (vec_cnt !== 8'd3 || vec_ready !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL done_ignores_valid: got vc=%0d rdy=%b done=%b, want 3 0 1", vec_cnt, vec_ready, done);
        end
    endtask

    task automatic test_mask();
        pulse_start();
        send(6'b110000, 2'b11, 2'b01, 2'b10);
        send(6'b001100, 2'b11, 2'b00, 2'b11);
        send(6'b000011, 2'b00, 2'b00, 2'b00);
        vec_valid = 1'b0;
        tests++;
        if (pass !== 1'b1 || err_cnt !== 8'd0 || first_err_valid !== 1'b0) begin
            fails++;
            $display("FAIL mask_hides: got pass=%b ec=%0d fev=%b, want 1 0 0", pass, err_cnt, first_err_valid);
        end
        pulse_start();
        send(6'b110000, 2'b11, 2'b01, 2'b00);
        send(6'b001100, 2'b11, 2'b00, 2'b11);
        send(6'b000011, 2'b00, 2'b00, 2'b00);
        vec_valid = 1'b0;
        tests++;
        if ({pass, err_cnt, first_err_valid, first_err_idx, first_err_vec, first_err_obs} !==
            {1'b0, 8'd1, 1'b1, 8'd0, 6'b110000, 2'b01}) begin
            fails++;
            $display("FAIL mask_open: got pass=%b ec=%0d fev=%b idx=%0d vec=%b obs=%b, want 0 1 1 0 110000 01",
                     pass, err_cnt, first_err_valid, first_err_idx, first_err_vec, first_err_obs);
        end
    endtask

    task automatic test_saturation();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_exp = 2'b00; s_obs = 2'b11; s_mask = 2'b00;
        for (int n = 0; n < 6; n++) begin
            logic rdy;
            rdy = 1'b0;
            s_vec_in = 6'(n + 1);
            s_valid = 1'b1;
            for (int i = 0; i < 20; i++) begin
                rdy = s_ready;
                tick();
                if (rdy) break;
            end
            if (!rdy) begin
                tests++; fails++;
                $display("FAIL sat_send_timeout: vector %0d not accepted", n);
            end
        end
        s_valid = 1'b0;
        tests++;
        if ({s_done, s_pass, s_err_cnt, s_vec_cnt, s_fei, s_fevec} !==
            {1'b1, 1'b0, 2'd3, 8'd6, 8'd0, 6'd1}) begin
            fails++;
            $display("FAIL saturation: got done=%b pass=%b ec=%0d vc=%0d idx=%0d vec=%b, want 1 0 3 6 0 000001",
                     s_done, s_pass, s_err_cnt, s_vec_cnt, s_fei, s_fevec);
        end
    endtask

    task automatic test_midrun_reset();
        pulse_start();
        send(6'b011100, 2'b01, 2'b00, 2'b00);
        send(6'b010101, 2'b10, 2'b10, 2'b00);
        vec_valid = 1'b0;
        tests++;
        if (vec_cnt !== 8'd2 || err_cnt !== 8'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: got vc=%0d ec=%0d busy=%b, want 2 1 1", vec_cnt, err_cnt, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({vec_ready, busy, done, pass, vec_cnt, err_cnt, first_err_valid,
             first_err_idx, first_err_vec, first_err_obs} !== '0) begin
            fails++;
            $display("FAIL midrun_reset: got rdy=%b busy=%b done=%b vc=%0d ec=%0d fev=%b, want all 0",
                     vec_ready, busy, done, vec_cnt, err_cnt, first_err_valid);
        end
        tick();
        rst_n = 1'b1;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || vec_cnt !== 8'd0 || vec_ready !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_idle: got busy=%b vc=%0d rdy=%b, want 0 0 0", busy, vec_cnt, vec_ready);
        end
    endtask

    task automatic test_restart();
        run_three(2'b00, 2'b11);
        tests++;
        if (done !== 1'b1 || err_cnt !== 8'd1 || first_err_valid !== 1'b1) begin
            fails++;
            $display("FAIL restart_setup: got done=%b ec=%0d fev=%b, want 1 1 1", done, err_cnt, first_err_valid);
        end
        pulse_start();
        tests++;
        if ({busy, done, vec_ready, pass, vec_cnt, err_cnt, first_err_valid, first_err_idx} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL restart_clear: got busy=%b done=%b rdy=%b pass=%b vc=%0d ec=%0d fev=%b idx=%0d, want 1 0 1 0 0 0 0 0",
                     busy, done, vec_ready, pass, vec_cnt, err_cnt, first_err_valid, first_err_idx);
        end
    endtask

    initial begin
        start = 1'b0; vec_valid = 1'b0; vec_in = '0;
        z_obs = '0; z_exp = '0; z_mask = '0;
        s_start = 1'b0; s_valid = 1'b0; s_vec_in = '0;
        s_obs = '0; s_exp = '0; s_mask = '0;
        test_reset();
        test_all_pass();
        test_first_err();
        test_stall();
        test_mask();
        test_saturation();
        test_midrun_reset();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
